// File: rtl/flow_idx_table.sv
// flow_idx_table -- per-flow buffer-index store.
//
// NUM_IDX independent index arrays of depth ELS = 2**FLOWID_W, IDX_W bits each.
// Every array has one write port and NUM_RD registered read ports. A read port
// has a one-cycle latency and uses valid/ready on both the request side and
// the response side. A new-flow init writes one value into every array in a
// single cycle. After reset, a hardware sweep writes zero to every entry. A
// read issued in the same cycle as a write or init to the same address
// returns the new data.
//
// Ports (array i = slice i; read port p of array i = slice k = i*NUM_RD+p):
//   clk, rst         clock, asynchronous active-high reset
//   wr_req_*         per-array write request (val/addr/data) and rdy
//   rd_req_*         per-port read request (val/addr) and rdy
//   rd_resp_*        per-port read response (val/data), consumed by rd_resp_rdy
//   rd_resp_addr     per-port address of the held response (optional, see below)
//   init_*           new-flow init (val/flowid/data) and rdy
//   clr_done         high once the post-reset sweep has finished
//
// Optional feature: define FLOW_IDX_TABLE_RESP_ADDR_EN to add output
// rd_resp_addr. It is registered and held together with rd_resp_data.
module flow_idx_table #(
   parameter int FLOWID_W = 3,
   parameter int IDX_W    = 9,
   parameter int NUM_IDX  = 3,
   parameter int NUM_RD   = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_IDX-1:0]                   wr_req_val,
   input  logic [NUM_IDX*FLOWID_W-1:0]          wr_req_addr,
   input  logic [NUM_IDX*IDX_W-1:0]             wr_req_data,
   output logic [NUM_IDX-1:0]                   wr_req_rdy,
   input  logic [NUM_IDX*NUM_RD-1:0]            rd_req_val,
   input  logic [NUM_IDX*NUM_RD*FLOWID_W-1:0]   rd_req_addr,
   output logic [NUM_IDX*NUM_RD-1:0]            rd_req_rdy,
   output logic [NUM_IDX*NUM_RD-1:0]            rd_resp_val,
   output logic [NUM_IDX*NUM_RD*IDX_W-1:0]      rd_resp_data,
`ifdef FLOW_IDX_TABLE_RESP_ADDR_EN
   output logic [NUM_IDX*NUM_RD*FLOWID_W-1:0]   rd_resp_addr,
`endif
   input  logic [NUM_IDX*NUM_RD-1:0]            rd_resp_rdy,
   input  logic                                 init_val,
   input  logic [FLOWID_W-1:0]                  init_flowid,
   input  logic [NUM_IDX*IDX_W-1:0]             init_data,
   output logic                                 init_rdy,
   output logic                                 clr_done
);
   localparam int ELS = 2**FLOWID_W;

   typedef enum logic {S_CLEAR, S_READY} state_e;

   state_e              state_q;
   logic [FLOWID_W-1:0] clr_addr_q;
   logic                clr_done_q;
   logic                ready;

   // Sweep FSM: one entry per cycle, ELS cycles total, then READY until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_CLEAR;
         clr_addr_q <= '0;
         clr_done_q <= 1'b0;
      end else if (state_q == S_CLEAR) begin
         clr_addr_q <= clr_addr_q + FLOWID_W'(1);
         if (clr_addr_q == FLOWID_W'(ELS-1)) begin
            state_q    <= S_READY;
            clr_done_q <= 1'b1;
         end
      end
   end

   assign ready      = (state_q == S_READY);
   assign clr_done   = clr_done_q;
   assign init_rdy   = ready;
   // Init takes every array's write slot, so all write ports stall for it.
   assign wr_req_rdy = {NUM_IDX{ready & ~init_val}};

   for (genvar i = 0; i < NUM_IDX; i++) begin : g_arr
      logic [IDX_W-1:0]    mem_q [ELS];
      logic                we;
      logic [FLOWID_W-1:0] wa;
      logic [IDX_W-1:0]    wd;

      // Single write port shared by sweep, init and the array's own write.
      always_comb begin
         we = 1'b0;
         wa = wr_req_addr[i*FLOWID_W +: FLOWID_W];
         wd = wr_req_data[i*IDX_W +: IDX_W];
         if (!ready) begin
            we = 1'b1;
            wa = clr_addr_q;
            wd = '0;
         end else if (init_val) begin
            we = 1'b1;
            wa = init_flowid;
            wd = init_data[i*IDX_W +: IDX_W];
         end else if (wr_req_val[i]) begin
            we = 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (we) mem_q[wa] <= wd;
      end

      for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
         localparam int K = i*NUM_RD + p;

         logic                rdy;
         logic                fire;
         logic [FLOWID_W-1:0] ra;
         logic [IDX_W-1:0]    rdata;
         logic                val_q, val_d;
         logic [IDX_W-1:0]    data_q, data_d;
         logic [FLOWID_W-1:0] addr_q, addr_d;

         assign ra   = rd_req_addr[K*FLOWID_W +: FLOWID_W];
         assign rdy  = ready & (~val_q | rd_resp_rdy[K]);
         assign fire = rd_req_val[K] & rdy;
         // Same-cycle write to the same entry wins over the stored value.
         assign rdata = (we && wa == ra) ? wd : mem_q[ra];

         // Response is a snapshot: it only changes on a newly accepted read.
         always_comb begin
            val_d  = val_q;
            data_d = data_q;
            addr_d = addr_q;
            if (fire) begin
               val_d  = 1'b1;
               data_d = rdata;
               addr_d = ra;
            end else if (rd_resp_rdy[K]) begin
               val_d  = 1'b0;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               val_q  <= 1'b0;
               data_q <= '0;
               addr_q <= '0;
            end else begin
               val_q  <= val_d;
               data_q <= data_d;
               addr_q <= addr_d;
            end
         end

         assign rd_req_rdy[K]                    = rdy;
         assign rd_resp_val[K]                   = val_q;
         assign rd_resp_data[K*IDX_W +: IDX_W]   = data_q;
`ifdef FLOW_IDX_TABLE_RESP_ADDR_EN
         assign rd_resp_addr[K*FLOWID_W +: FLOWID_W] = addr_q;
`else
         logic unused_addr;
         assign unused_addr = ^addr_q;
`endif
      end
   end
endmodule

// File: tb/tb_flow_idx_table.sv
// tb_flow_idx_table -- directed self-checking bench for flow_idx_table.
// Inputs are driven at the falling edge; outputs are sampled at the falling
// edge (or #1 after an input change for combinational ready signals).
module tb_flow_idx_table;
   localparam int FW = 3;
   localparam int IW = 9;
   localparam int NI = 3;
   localparam int NR = 2;
   localparam int NP = NI*NR;

   logic               clk = 1'b0;
   logic               rst;
   logic [NI-1:0]      wr_req_val;
   logic [NI*FW-1:0]   wr_req_addr;
   logic [NI*IW-1:0]   wr_req_data;
   logic [NI-1:0]      wr_req_rdy;
   logic [NP-1:0]      rd_req_val;
   logic [NP*FW-1:0]   rd_req_addr;
   logic [NP-1:0]      rd_req_rdy;
   logic [NP-1:0]      rd_resp_val;
   logic [NP*IW-1:0]   rd_resp_data;
`ifdef FLOW_IDX_TABLE_RESP_ADDR_EN
   logic [NP*FW-1:0]   rd_resp_addr;
`endif
   logic [NP-1:0]      rd_resp_rdy;
   logic               init_val;
   logic [FW-1:0]      init_flowid;
   logic [NI*IW-1:0]   init_data;
   logic               init_rdy;
   logic               clr_done;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   flow_idx_table #(.FLOWID_W(FW), .IDX_W(IW), .NUM_IDX(NI), .NUM_RD(NR)) dut (
      .clk(clk), .rst(rst),
      .wr_req_val(wr_req_val), .wr_req_addr(wr_req_addr),
      .wr_req_data(wr_req_data), .wr_req_rdy(wr_req_rdy),
      .rd_req_val(rd_req_val), .rd_req_addr(rd_req_addr), .rd_req_rdy(rd_req_rdy),
      .rd_resp_val(rd_resp_val), .rd_resp_data(rd_resp_data),
`ifdef FLOW_IDX_TABLE_RESP_ADDR_EN
      .rd_resp_addr(rd_resp_addr),
`endif
      .rd_resp_rdy(rd_resp_rdy),
      .init_val(init_val), .init_flowid(init_flowid), .init_data(init_data),
      .init_rdy(init_rdy), .clr_done(clr_done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Single read on port p of array i with the response consumed at once.
   task automatic rd_chk(input string tag, input int i, input int p,
                         input logic [FW-1:0] a, input logic [IW-1:0] exp);
      int k;
      k = i*NR + p;
      rd_req_val[k]           = 1'b1;
      rd_req_addr[k*FW +: FW] = a;
      rd_resp_rdy[k]          = 1'b1;
      @(negedge clk);
      rd_req_val[k] = 1'b0;
      chk({tag, "_val"}, 64'(rd_resp_val[k]), 64'd1);
      chk({tag, "_data"}, 64'(rd_resp_data[k*IW +: IW]), 64'(exp));
`ifdef FLOW_IDX_TABLE_RESP_ADDR_EN
      chk({tag, "_addr"}, 64'(rd_resp_addr[k*FW +: FW]), 64'(a));
`endif
      @(negedge clk);
      rd_resp_rdy[k] = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      wr_req_val = '0; wr_req_addr = '0; wr_req_data = '0;
      rd_req_val = '0; rd_req_addr = '0; rd_resp_rdy = '0;
      init_val = 1'b0; init_flowid = '0; init_data = '0;

      // 1: reset state and post-reset sweep length
      repeat (2) @(negedge clk);
      chk("rst_clr_done", 64'(clr_done), 64'd0);
      chk("rst_resp_val", 64'(rd_resp_val), 64'd0);
      chk("rst_resp_data", 64'(rd_resp_data), 64'd0);
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk("sweep_clr_done", 64'(clr_done), 64'd0);
         chk("sweep_init_rdy", 64'(init_rdy), 64'd0);
         chk("sweep_wr_rdy", 64'(wr_req_rdy), 64'd0);
         chk("sweep_rd_rdy", 64'(rd_req_rdy), 64'd0);
         @(negedge clk);
      end
      chk("sweep_done", 64'(clr_done), 64'd1);
      chk("ready_init_rdy", 64'(init_rdy), 64'd1);
      chk("ready_wr_rdy", 64'(wr_req_rdy), 64'h7);
      chk("ready_rd_rdy", 64'(rd_req_rdy), 64'h3F);
      rd_chk("zero_a0f0", 0, 0, 3'd0, 9'h000);
      rd_chk("zero_a1f7", 1, 1, 3'd7, 9'h000);
      rd_chk("zero_a2f4", 2, 0, 3'd4, 9'h000);

      // 2: new-flow init writes all three arrays
      init_val = 1'b1; init_flowid = 3'd5;
      init_data = {9'h030, 9'h020, 9'h010};
      #1 chk("init_rdy", 64'(init_rdy), 64'd1);
      @(negedge clk);
      init_val = 1'b0;
      rd_chk("init_a1", 1, 0, 3'd5, 9'h020);
      rd_chk("init_a0", 0, 1, 3'd5, 9'h010);
      rd_chk("init_a2", 2, 1, 3'd5, 9'h030);

      // 3: init beats a same-cycle write; the write lands a cycle later
      init_val = 1'b1; init_flowid = 3'd2;
      init_data = {9'h003, 9'h002, 9'h001};
      wr_req_val[0] = 1'b1; wr_req_addr[0 +: FW] = 3'd2; wr_req_data[0 +: IW] = 9'h0AA;
      rd_req_val[1] = 1'b1; rd_req_addr[1*FW +: FW] = 3'd2; rd_resp_rdy[1] = 1'b1;
      #1;
      chk("prio_wr_rdy", 64'(wr_req_rdy), 64'h0);
      chk("prio_rd_rdy", 64'(rd_req_rdy[1]), 64'd1);
      @(negedge clk);
      chk("prio_rd_init", 64'(rd_resp_data[1*IW +: IW]), 64'h001);
      init_val = 1'b0;
      #1 chk("prio_wr_rdy_after", 64'(wr_req_rdy[0]), 64'd1);
      @(negedge clk);
      chk("prio_rd_write", 64'(rd_resp_data[1*IW +: IW]), 64'h0AA);
      wr_req_val = '0; rd_req_val = '0;
      @(negedge clk);
      chk("prio_resp_drop", 64'(rd_resp_val[1]), 64'd0);
      rd_resp_rdy = '0;
      rd_chk("prio_a0_final", 0, 0, 3'd2, 9'h0AA);
      rd_chk("prio_a1_init", 1, 0, 3'd2, 9'h002);

      // 4: write/read bypass on two ports of array 2
      wr_req_val[2] = 1'b1; wr_req_addr[2*FW +: FW] = 3'd3; wr_req_data[2*IW +: IW] = 9'h1FF;
      rd_req_val[4] = 1'b1; rd_req_addr[4*FW +: FW] = 3'd3; rd_resp_rdy[4] = 1'b1;
      rd_req_val[5] = 1'b1; rd_req_addr[5*FW +: FW] = 3'd3; rd_resp_rdy[5] = 1'b1;
      @(negedge clk);
      wr_req_val = '0; rd_req_val = '0;
      chk("byp_p0", 64'(rd_resp_data[4*IW +: IW]), 64'h1FF);
      chk("byp_p1", 64'(rd_resp_data[5*IW +: IW]), 64'h1FF);
      @(negedge clk);
      rd_resp_rdy = '0;
      rd_chk("byp_a2f3_kept", 2, 0, 3'd3, 9'h1FF);
      rd_chk("byp_a1f3_other", 1, 1, 3'd3, 9'h000);

      // 5: held response is a stable snapshot under backpressure
      rd_req_val[0] = 1'b1; rd_req_addr[0 +: FW] = 3'd2; rd_resp_rdy[0] = 1'b0;
      @(negedge clk);
      rd_req_val[0] = 1'b0;
      wr_req_val[0] = 1'b1; wr_req_addr[0 +: FW] = 3'd2; wr_req_data[0 +: IW] = 9'h055;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("hold_val", 64'(rd_resp_val[0]), 64'd1);
         chk("hold_data", 64'(rd_resp_data[0 +: IW]), 64'h0AA);
         chk("hold_req_rdy", 64'(rd_req_rdy[0]), 64'd0);
         @(negedge clk);
         wr_req_val = '0;
      end
      rd_resp_rdy[0] = 1'b1;
      #1 chk("hold_req_rdy_release", 64'(rd_req_rdy[0]), 64'd1);
      @(negedge clk);
      chk("hold_consumed", 64'(rd_resp_val[0]), 64'd0);
      rd_resp_rdy[0] = 1'b0;
      rd_chk("hold_new_data", 0, 0, 3'd2, 9'h055);

      // 6: reset mid-sweep restarts the sweep
      rst = 1'b1;
      #1;
      chk("rst2_clr_done", 64'(clr_done), 64'd0);
      chk("rst2_resp_data", 64'(rd_resp_data), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst3_mid_sweep", 64'(clr_done), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk("resweep_clr_done", 64'(clr_done), 64'd0);
         chk("resweep_init_rdy", 64'(init_rdy), 64'd0);
         @(negedge clk);
      end
      chk("resweep_done", 64'(clr_done), 64'd1);
      rd_chk("resweep_a0f5", 0, 0, 3'd5, 9'h000);
      rd_chk("resweep_a0f2", 0, 1, 3'd2, 9'h000);
      rd_chk("resweep_a2f3", 2, 0, 3'd3, 9'h000);
      rd_chk("resweep_a1f2", 1, 0, 3'd2, 9'h000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
